// File: rtl/sar_search_ctrl_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, comparator mask codes and the default operand width.
package sar_search_ctrl_pkg;

    localparam int SAR_WIDTH_DEFAULT = 8;

    localparam logic [SAR_WIDTH_DEFAULT-1:0] MASK_GE = {SAR_WIDTH_DEFAULT{1'b1}};
    localparam logic [SAR_WIDTH_DEFAULT-1:0] MASK_LT = {SAR_WIDTH_DEFAULT{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TEST = 2'd1,
        ST_DONE = 2'd2
    } sar_state_e;

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-searches a hidden comparator operand A by driving trial values on
// operand B and resolving one bit per cycle from the comparator mask.
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cmp_mask,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             mask_ge;
    logic             mask_bad;
    logic [IDX_W-1:0] idx_next;

    // A malformed mask is flagged and resolved as "A below trial".
    assign mask_ge  = (cmp_mask == {WIDTH{1'b1}});
    assign mask_bad = !mask_ge && (cmp_mask != {WIDTH{1'b0}});
    assign idx_next = bit_idx_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        result_d  = result_q;
        bit_idx_d = bit_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_TEST;
                    trial_d   = TOP_BIT;
                    bit_idx_d = TOP_IDX;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                end
            end
            ST_TEST: begin
                if (mask_bad) begin
                    err_d = 1'b1;
                end
                trial_d[bit_idx_q] = mask_ge;
                if (bit_idx_q != '0) begin
                    trial_d[idx_next] = 1'b1;
                    bit_idx_d         = idx_next;
                end else begin
                    result_d = trial_d;
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            trial_q   <= '0;
            result_q  <= '0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            trial_q   <= trial_d;
            result_q  <= result_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign trial  = trial_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
Successive-approximation controller that drives the B operand of the team's 8-bit magnitude comparator (A >= B gives mask 8'hFF, otherwise 8'h00) and consumes its 8-bit mask output. It binary-searches a hidden A value presented to the comparator by some other block. The search recovers A exactly in WIDTH cycles. It sits beside the comparator in the lab datapath and hands the recovered value to display/readout logic.

Parameters:
WIDTH, 8, operand width; it also sets the search length in cycles.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new search; sampled only in IDLE
cmp_mask  input  WIDTH  comparator output; all-ones means A >= trial, all-zeros means A < trial
trial  output  WIDTH  registered trial value; drives comparator input B
busy  output  1  high while in TEST
done  output  1  one-cycle pulse when result is updated
result  output  WIDTH  last completed search value; held until the next done
err  output  1  sticky; set if cmp_mask was neither all-ones nor all-zeros during TEST

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - trial, result and bit_idx are all 0.
  - busy, done and err are all 0.
  - rst has priority over every other input, including mid-search. No partial result is written.
- States: IDLE, TEST, DONE.
- IDLE:
  - If start=1 at an edge: state<=TEST, trial<=1<<(WIDTH-1), bit_idx<=WIDTH-1, busy<=1, err<=0.
  - Otherwise all outputs are held.
- TEST, at each edge with bit_idx=k:
  - ge = (cmp_mask == all-ones).
  - bad = cmp_mask not all-ones and not all-zeros. If bad: err<=1 and the trial is treated as ge=0.
  - Bit k of trial is kept if ge, otherwise cleared.
  - If k>0: bit k-1 is set and bit_idx<=k-1.
  - If k==0: result<=final trial (with bit 0 resolved), state<=DONE, done<=1, busy<=0.
  - trial holds the final value in DONE/IDLE.
- DONE: lasts exactly one cycle.
  - done is high.
  - start is ignored.
  - Next edge: state<=IDLE, done<=0.
- Timing:
  - cmp_mask is combinational from trial within the same cycle; the path is trial reg -> comparator -> controller.
  - If start is sampled at edge e0, done is high during the cycle after edge e0+WIDTH.
  - The minimum start-to-start period is WIDTH+2 cycles when start is held high.
- Width rules:
  - trial and result are unsigned, WIDTH bits. No arithmetic is performed; only bit set/clear.
  - A=0 yields 0. A=all-ones yields all-ones.
- start asserted during TEST or DONE: ignored, not queued.
- err clears only on reset or on the next accepted start.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, TEST, DONE};
  - MASK_GE = all-ones;
  - MASK_LT = all-zeros;
  - the WIDTH default.
- Single module; no sub-module needed.
- The bench instantiates the existing comparator with the hidden A driven by the testbench.

Test Plan:
- A=8'h5A, pulse start -> trial sequence 80,40,60,50,58,5C,5A,5B across TEST cycles; result=8'h5A; done pulses once, 9 edges after start; err=0.
- A=8'hFF, then A=8'h00 (separate runs) -> result=8'hFF then 8'h00; trial sequence ends FF and 01 respectively.
- start held high with A=8'h33 -> back-to-back searches; done pulses every 10 cycles; result stays 8'h33; start ignored in TEST/DONE.
- Bench forces cmp_mask=8'h0F at bit_idx=3, A=8'hAA -> err=1, bit 3 cleared; err stays 1 until the next start, which clears it.
- rst=1 asserted on the 4th TEST cycle -> next cycle state IDLE; trial=0, result=0, busy=0, done=0, err=0; no done pulse.
- Reset mid-search after a prior result 8'h5A -> result reads 0 after the reset edge, confirming reset overrides the held result.
